bcd_operand_loader: RTL and testbench

BCD_OPERAND_LOADER -- requirements
Module: bcd_operand_loader

---
 rtl/bcd_pkg.sv | 20 ++
 rtl/debounce.sv | 55 +++++
 rtl/bcd_operand_loader.sv | 114 +++++++++++
 tb/tb_bcd_operand_loader.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD operand loader: FSM state encoding,
// digit type and the legal-digit check used when capturing operands.
package bcd_pkg;

   typedef enum logic [1:0] {
      ESPERA_A = 2'd0,
      ESPERA_B = 2'd1,
      PRONTO   = 2'd2,
      ERRO     = 2'd3
   } estado_t;

   typedef logic [3:0] digito_t;

   localparam digito_t DIGITO_MAX = 4'd9;

   function automatic logic digito_ok(input digito_t d);
      return (d <= DIGITO_MAX);
   endfunction

endpackage

// File: rtl/debounce.sv
// Push-button front end: 2-flop synchronizer, stability-count debouncer and a
// one-cycle press pulse on every accepted 1->0 level transition.
module debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic in_n,
   output logic press
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             level_q;
   logic             level_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Synchronizer flops, accepted level and stability counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b1;
         cnt_q   <= {CNT_W{1'b0}};
      end else begin
         sync1_q <= in_n;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   // Level acceptance; the pulse is combinational so the consumer updates on
   // the same edge that flips the accepted level.
   always_comb begin
      level_d = level_q;
      cnt_d   = {CNT_W{1'b0}};
      press   = 1'b0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            press   = level_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else begin
         cnt_d = {CNT_W{1'b0}};
      end
   end

endmodule

// File: rtl/bcd_operand_loader.sv
// Captures two BCD operands and a carry from switches, one per debounced
// button press, and flags illegal digits; outputs feed the BCD digit adder.
module bcd_operand_loader
   import bcd_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] digito,
   input  logic       carry_in,
   input  logic       load_n,
   output logic [3:0] a,
   output logic [3:0] b,
   output logic       cin,
   output logic       valid,
   output logic       erro,
   output logic [1:0] estado
);

   logic    press_s;
   estado_t state_q;
   estado_t state_d;
   digito_t a_q;
   digito_t a_d;
   digito_t b_q;
   digito_t b_d;
   logic    cin_q;
   logic    cin_d;
   logic    valid_q;
   logic    valid_d;
   logic    erro_q;
   logic    erro_d;

   debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk   (clk),
      .rst   (rst),
      .in_n  (load_n),
      .press (press_s)
   );

   // State and operand registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ESPERA_A;
         a_q     <= 4'd0;
         b_q     <= 4'd0;
         cin_q   <= 1'b0;
         valid_q <= 1'b0;
         erro_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cin_q   <= cin_d;
         valid_q <= valid_d;
         erro_q  <= erro_d;
      end
   end

   // Capture sequencing; switches are looked at only in the press cycle.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      cin_d   = cin_q;
      valid_d = valid_q;
      erro_d  = erro_q;
      if (press_s) begin
         case (state_q)
            ESPERA_A, PRONTO: begin
               valid_d = 1'b0;
               if (digito_ok(digito)) begin
                  a_d     = digito;
                  state_d = ESPERA_B;
               end else begin
                  erro_d  = 1'b1;
                  state_d = ERRO;
               end
            end
            ESPERA_B: begin
               if (digito_ok(digito)) begin
                  b_d     = digito;
                  cin_d   = carry_in;
                  valid_d = 1'b1;
                  state_d = PRONTO;
               end else begin
                  erro_d  = 1'b1;
                  state_d = ERRO;
               end
            end
            ERRO: begin
               erro_d  = 1'b0;
               state_d = ESPERA_A;
            end
            default: begin
               state_d = ESPERA_A;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   assign a      = a_q;
   assign b      = b_q;
   assign cin    = cin_q;
   assign valid  = valid_q;
   assign erro   = erro_q;
   assign estado = state_q;

endmodule

// File: tb/tb_bcd_operand_loader.sv
// Self-checking bench for bcd_operand_loader with a short debounce window.
module tb_bcd_operand_loader;

   localparam int N = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] digito;
   logic       carry_in;
   logic       load_n;
   logic [3:0] a;
   logic [3:0] b;
   logic       cin;
   logic       valid;
   logic       erro;
   logic [1:0] estado;

   int n_vec = 0;
   int n_err = 0;

   bcd_operand_loader #(.DEBOUNCE_CYCLES(N)) dut (
      .clk      (clk),
      .rst      (rst),
      .digito   (digito),
      .carry_in (carry_in),
      .load_n   (load_n),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .valid    (valid),
      .erro     (erro),
      .estado   (estado)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: raw button delayed two edges, a run of N samples that
   // disagree with the accepted level flips it, a falling flip is a press.
   bit m_pipe [2];
   bit m_hist [$];
   bit m_level;
   bit m_live = 1'b0;
   int m_state, m_a, m_b, m_cin, m_valid, m_erro;

   task automatic m_press();
      int d;
      d = int'(digito);
      case (m_state)
         0, 2: begin
            m_valid = 0;
            if (d <= 9) begin m_a = d; m_state = 1; end
            else begin m_erro = 1; m_state = 3; end
         end
         1: begin
            if (d <= 9) begin m_b = d; m_cin = int'(carry_in); m_valid = 1; m_state = 2; end
            else begin m_erro = 1; m_state = 3; end
         end
         default: begin m_erro = 0; m_state = 0; end
      endcase
   endtask

   initial forever begin
      bit samp;
      @(posedge clk);
      if (rst) begin
         m_pipe[0] = 1'b1; m_pipe[1] = 1'b1;
         m_hist.delete();
         m_level = 1'b1;
         m_state = 0; m_a = 0; m_b = 0; m_cin = 0; m_valid = 0; m_erro = 0;
         m_live = 1'b1;
      end else begin
         samp = m_pipe[1];
         m_pipe[1] = m_pipe[0];
         m_pipe[0] = load_n;
         if (samp == m_level) begin
            m_hist.delete();
         end else begin
            m_hist.push_back(samp);
            if (m_hist.size() == N) begin
               m_level = samp;
               m_hist.delete();
               if (samp == 1'b0) m_press();
            end
         end
      end
   end

   // Every-cycle comparison against the model.
   initial forever begin
      @(negedge clk);
      if (m_live) begin
         chk("mdl_a", a, m_a);
         chk("mdl_b", b, m_b);
         chk("mdl_cin", cin, m_cin);
         chk("mdl_valid", valid, m_valid);
         chk("mdl_erro", erro, m_erro);
         chk("mdl_estado", estado, m_state);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input int d, input bit c);
      digito = 4'(d); carry_in = c; load_n = 1'b0;
      cyc(10);
      digito = 4'hF; carry_in = ~c; load_n = 1'b1;
      cyc(10);
   endtask

   // Cycles from the negedge where the wait starts to the first change of estado.
   task automatic wait_change(input logic [1:0] st0, output int lat);
      lat = -1;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (lat < 0 && estado != st0) lat = i;
      end
   endtask

   initial begin
      int lat;
      rst = 1'b1; load_n = 1'b1; digito = 4'd0; carry_in = 1'b0;
      cyc(3);
      chk("rst_a", a, 0); chk("rst_b", b, 0); chk("rst_cin", cin, 0);
      chk("rst_valid", valid, 0); chk("rst_erro", erro, 0); chk("rst_estado", estado, 0);
      rst = 1'b0;
      cyc(3);

      digito = 4'd7; carry_in = 1'b0; load_n = 1'b0;
      wait_change(2'd0, lat);
      chk("latency", lat, 6); chk("a_7", a, 7); chk("estado_1", estado, 1);
      digito = 4'hF; load_n = 1'b1; cyc(10);

      press(5, 1'b1);
      chk("op_a", a, 7); chk("op_b", b, 5); chk("op_cin", cin, 1);
      chk("op_valid", valid, 1); chk("op_estado", estado, 2);

      press(3, 1'b0);
      chk("pr_valid", valid, 0); chk("pr_a", a, 3); chk("pr_estado", estado, 1); chk("pr_b", b, 5);

      load_n = 1'b0; cyc(3); load_n = 1'b1; cyc(2); load_n = 1'b0; cyc(3); load_n = 1'b1; cyc(10);
      chk("bounce_estado", estado, 1); chk("bounce_a", a, 3);

      press(9, 1'b1);
      chk("p2_b", b, 9); chk("p2_estado", estado, 2);
      press(12, 1'b0);
      chk("errp_erro", erro, 1); chk("errp_estado", estado, 3);
      chk("errp_valid", valid, 0); chk("errp_a", a, 3);
      press(1, 1'b0);
      chk("clr_erro", erro, 0); chk("clr_estado", estado, 0);
      chk("clr_a", a, 3); chk("clr_b", b, 9); chk("clr_cin", cin, 1);

      press(12, 1'b1);
      chk("erra_erro", erro, 1); chk("erra_estado", estado, 3); chk("erra_a", a, 3);
      press(0, 1'b0);
      chk("clr2_estado", estado, 0);

      press(4, 1'b0);
      chk("hold_a", a, 4); chk("hold_estado", estado, 1);
      press(10, 1'b1);
      chk("errb_erro", erro, 1); chk("errb_estado", estado, 3); chk("errb_b", b, 9);
      press(2, 1'b0);
      press(1, 1'b0);
      press(2, 1'b1);
      chk("p3_estado", estado, 2); chk("p3_a", a, 1); chk("p3_b", b, 2); chk("p3_cin", cin, 1);

      digito = 4'd2; carry_in = 1'b0; load_n = 1'b0;
      cyc(1);
      rst = 1'b1;
      cyc(3);
      chk("rst2_a", a, 0); chk("rst2_b", b, 0); chk("rst2_cin", cin, 0);
      chk("rst2_valid", valid, 0); chk("rst2_estado", estado, 0);
      rst = 1'b0;
      wait_change(2'd0, lat);
      chk("held_latency", lat, 6); chk("held_a", a, 2);
      load_n = 1'b1; cyc(10);

      load_n = 1'b0; cyc(4);
      rst = 1'b1; cyc(1);
      rst = 1'b0; cyc(2);
      load_n = 1'b1; cyc(12);
      chk("midrst_estado", estado, 0); chk("midrst_a", a, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      n_err++;
      $display("FAIL watchdog: got timeout, expected completion");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $fatal(1, "watchdog");
   end

endmodule
